// File: rtl/mcb_port_arbiter.sv
// Round-robin burst arbiter sharing one Spartan-6 MCB user port among
// NUM_CH client channels. One channel is granted at a time. Its write data
// is pushed into the MCB write FIFO ahead of the command. Read data is
// popped from the first-word-fall-through read FIFO after the command.
module mcb_port_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 30
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         calib_done,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*6-1:0]          ch_bl,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_wack,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [NUM_CH-1:0]            ch_done,
  output logic                         busy,
  output logic                         p_cmd_en,
  output logic [2:0]                   p_cmd_instr,
  output logic [5:0]                   p_cmd_bl,
  output logic [ADDR_WIDTH-1:0]        p_cmd_byte_addr,
  input  logic                         p_cmd_full,
  output logic                         p_wr_en,
  output logic [DATA_WIDTH-1:0]        p_wr_data,
  output logic [DATA_WIDTH/8-1:0]      p_wr_mask,
  input  logic                         p_wr_full,
  output logic                         p_rd_en,
  input  logic [DATA_WIDTH-1:0]        p_rd_data,
  input  logic                         p_rd_empty
);

  localparam int unsigned IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_CMD,
    RD_CMD,
    RD_DATA,
    DONE
  } state_t;

  state_t                  state;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           last_grant;
  logic [5:0]              cnt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_found;
  logic [IW:0]             pick_sum;
  logic [NUM_CH-1:0]       gnt_onehot;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [5:0]              sel_bl;

  // Round-robin search starting one past the last served channel; the sum is
  // one bit wider so the wrap back to zero is a single conditional subtract.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      pick_sum = {1'b0, last_grant} + (IW+1)'(i);
      if (pick_sum >= (IW+1)'(NUM_CH)) begin
        pick_sum = pick_sum - (IW+1)'(NUM_CH);
      end
      if (!pick_found && ch_req[pick_sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[IW-1:0];
      end
    end
  end

  assign sel_addr = ch_addr[32'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_bl   = ch_bl[32'(pick_idx)*6 +: 6];

  // Transaction sequencer: grant, data/command phases, completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      gnt_idx         <= '0;
      last_grant      <= IW'(NUM_CH - 1);
      cnt             <= '0;
      p_cmd_instr     <= '0;
      p_cmd_bl        <= '0;
      p_cmd_byte_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (calib_done && pick_found) begin
            gnt_idx         <= pick_idx;
            p_cmd_instr     <= ch_we[pick_idx] ? 3'b000 : 3'b001;
            p_cmd_bl        <= sel_bl;
            p_cmd_byte_addr <= sel_addr & ALIGN_MASK;
            cnt             <= sel_bl;
            state           <= ch_we[pick_idx] ? WR_DATA : RD_CMD;
          end
        end
        WR_DATA: begin
          if (!p_wr_full) begin
            if (cnt == '0) state <= WR_CMD;
            else           cnt   <= cnt - 6'd1;
          end
        end
        WR_CMD: begin
          if (!p_cmd_full) state <= DONE;
        end
        RD_CMD: begin
          if (!p_cmd_full) begin
            cnt   <= p_cmd_bl;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (!p_rd_empty) begin
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - 6'd1;
          end
        end
        DONE: begin
          last_grant <= gnt_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO handshakes follow the full/empty flags directly so a stall costs no
  // extra cycle; everything else is decoded from registered state.
  always_comb begin
    gnt_onehot = NUM_CH'(1) << gnt_idx;
    busy       = (state != IDLE);
    ch_gnt     = busy ? gnt_onehot : '0;
    p_wr_en    = (state == WR_DATA) && !p_wr_full;
    p_wr_data  = ch_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    p_wr_mask  = '0;
    ch_wack    = p_wr_en ? gnt_onehot : '0;
    p_cmd_en   = ((state == WR_CMD) || (state == RD_CMD)) && !p_cmd_full;
    p_rd_en    = (state == RD_DATA) && !p_rd_empty;
    ch_rdata   = p_rd_data;
    ch_rvalid  = p_rd_en ? gnt_onehot : '0;
    ch_done    = (state == DONE) ? gnt_onehot : '0;
  end

endmodule
